// File: rtl/fifo_sched_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sched_pkg
//   Shared types and helpers for the round-robin FIFO read scheduler.
//   - sched_state_t : scheduler FSM states (IDLE between grants, BURST while
//                     draining the granted channel)
//   - STAT_W        : width of the optional per-channel pop counters
//   - ch_w(n)       : width of a channel index for n channels
// -----------------------------------------------------------------------------
package fifo_sched_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_t;

    localparam int STAT_W = 16;

    function automatic int ch_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational rotating-priority arbiter. The search starts at the index
//   just after `last` and wraps from N-1 to 0, so the channel granted last time
//   has the lowest priority this time.
//
// Ports
//   req       in   N     request vector (1 = channel wants service)
//   last      in   W     index of the previous grant, W = ch_w(N)
//   gnt_idx   out  W     winning channel index (0 when nothing requests)
//   gnt_valid out  1     at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import fifo_sched_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = ch_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_valid
);

    // Walk offsets from farthest to nearest so the nearest requester after
    // `last` is the final assignment and therefore wins.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_sched.sv
// -----------------------------------------------------------------------------
// fifo_rr_sched
//   Round-robin read scheduler draining NUM_CH first-word-fall-through FIFOs
//   into one valid/ready stream. Each output word is tagged with its source
//   channel. A grant keeps a channel for at most BURST_MAX pops, or until the
//   channel runs dry, then the scheduler spends one IDLE cycle re-arbitrating.
//
// Parameters
//   NUM_CH      number of FIFO read ports (>=2)
//   DATA_WIDTH  word width
//   BURST_MAX   max pops per grant (>=1)
//
// Ports
//   clk        in   1                  clock
//   rst_n      in   1                  asynchronous reset, active low
//   ch_empty   in   NUM_CH             per-channel FIFO empty flag
//   ch_data    in   NUM_CH*DATA_WIDTH  per-channel head word, ch i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ch_inc     out  NUM_CH             per-channel pop strobe (combinational, one-hot or zero)
//   out_valid  out  1                  output word valid (registered)
//   out_ready  in   1                  sink accepts word
//   out_data   out  DATA_WIDTH         output word (registered)
//   out_ch     out  CH_W               source channel of out_data
//   pop_cnt    out  NUM_CH*16          per-channel wrapping pop counters,
//                                      only when FIFO_RR_SCHED_STATS_EN is defined
// -----------------------------------------------------------------------------
module fifo_rr_sched
    import fifo_sched_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int BURST_MAX  = 4,
    localparam int CH_W       = ch_w(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            ch_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]            ch_inc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              out_ch
`ifdef FIFO_RR_SCHED_STATS_EN
    ,
    output logic [NUM_CH*STAT_W-1:0]     pop_cnt
`endif
);

    localparam int                CNT_W      = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0]  BURST_LIM  = CNT_W'(BURST_MAX);
    localparam logic [CH_W-1:0]   LAST_RESET = CH_W'(NUM_CH - 1);

    sched_state_t           state_reg;
    logic [CH_W-1:0]        grant_reg;
    logic [CH_W-1:0]        last_grant_reg;
    logic [CNT_W-1:0]       burst_cnt_reg;
    logic                   out_valid_reg;
    logic [DATA_WIDTH-1:0]  out_data_reg;
    logic [CH_W-1:0]        out_ch_reg;

    logic [DATA_WIDTH-1:0]  ch_word [NUM_CH];
    logic [CH_W-1:0]        arb_idx;
    logic                   arb_valid;
    logic                   can_load;
    logic                   burst_open;
    logic                   grant_empty;
    logic                   pop;
    logic [DATA_WIDTH-1:0]  grant_data;
    logic [CNT_W-1:0]       burst_cnt_next;

    // Unpack the flat head-word bus into an indexable array.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_word[gi] = ch_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .N(NUM_CH)
    ) u_arb (
        .req       (~ch_empty),
        .last      (last_grant_reg),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    // The output register can take a new word when it is empty or its current
    // word is leaving this cycle.
    assign can_load       = !out_valid_reg || out_ready;
    assign burst_open     = (burst_cnt_reg < BURST_LIM);
    assign grant_empty    = ch_empty[grant_reg];
    assign grant_data     = ch_word[grant_reg];
    assign burst_cnt_next = burst_cnt_reg + 1'b1;

    // Pop strobes are only raised in BURST for the granted channel; in reset
    // the state is forced to IDLE so every strobe is low.
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_inc
            assign ch_inc[gi] = (state_reg == BURST) && (grant_reg == CH_W'(gi)) &&
                                can_load && !ch_empty[gi] && burst_open;
        end
    endgenerate

    assign pop = |ch_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= LAST_RESET;
            burst_cnt_reg  <= '0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_ch_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // The last word of the previous burst may still be waiting
                    // for the sink during this cycle.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                    if (arb_valid) begin
                        grant_reg      <= arb_idx;
                        last_grant_reg <= arb_idx;
                        burst_cnt_reg  <= '0;
                        state_reg      <= BURST;
                    end
                end
                BURST: begin
                    if (pop) begin
                        out_data_reg  <= grant_data;
                        out_ch_reg    <= grant_reg;
                        out_valid_reg <= 1'b1;
                        burst_cnt_reg <= burst_cnt_next;
                        // Leave on the edge that uses up the burst allowance.
                        if (burst_cnt_next == BURST_LIM) begin
                            state_reg <= IDLE;
                        end
                    end else if (can_load) begin
                        if (out_ready) begin
                            out_valid_reg <= 1'b0;
                        end
                        if (grant_empty) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;

`ifdef FIFO_RR_SCHED_STATS_EN
    // Per-channel pop counters; 16-bit wrap is intentional.
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_stats
            logic [STAT_W-1:0] pop_cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pop_cnt_reg <= '0;
                end else if (ch_inc[gi]) begin
                    pop_cnt_reg <= pop_cnt_reg + 1'b1;
                end
            end
            assign pop_cnt[gi*STAT_W +: STAT_W] = pop_cnt_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_fifo_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_fifo_rr_sched
//   Directed bench for fifo_rr_sched (NUM_CH=4, DATA_WIDTH=8, BURST_MAX=4).
//   Per-channel FIFOs are modelled with queues; accepted output words are
//   collected and compared against hand-written expected sequences.
//   The pop counter scenario is built only with FIFO_RR_SCHED_STATS_EN.
// -----------------------------------------------------------------------------
module tb_fifo_rr_sched;

    localparam int NUM_CH = 4;
    localparam int DW     = 8;
    localparam int BM     = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] ch_empty;
    logic [NUM_CH*DW-1:0] ch_data;
    logic [NUM_CH-1:0] ch_inc;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_ch;
`ifdef FIFO_RR_SCHED_STATS_EN
    logic [NUM_CH*16-1:0] pop_cnt;
`endif

    always #5 clk = ~clk;

    fifo_rr_sched #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DW),
        .BURST_MAX  (BM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_empty  (ch_empty),
        .ch_data   (ch_data),
        .ch_inc    (ch_inc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
`ifdef FIFO_RR_SCHED_STATS_EN
        ,
        .pop_cnt   (pop_cnt)
`endif
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    logic [DW-1:0] fifo_q [NUM_CH][$];
    logic [9:0]    rx_q [$];
    int            rx_cyc [$];

    logic [NUM_CH-1:0] inc_seen;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_data;
    logic [1:0]        s_ch;

    task automatic refresh();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_empty[i] = (fifo_q[i].size() == 0);
            ch_data[i*DW +: DW] = ch_empty[i] ? 8'h00 : fifo_q[i][0];
        end
    endtask

    // One clock: sample at the falling edge, pop the model FIFOs after the
    // rising edge according to the strobes seen, then update the FIFO outputs.
    task automatic tick();
        @(negedge clk);
        inc_seen = ch_inc;
        s_valid  = out_valid;
        s_ready  = out_ready;
        s_data   = out_data;
        s_ch     = out_ch;
        vec_cnt++;
        if (($countones(ch_inc) > 1) || ((ch_inc & ch_empty) != '0)) begin
            err_cnt++;
            $display("FAIL pop_strobe cyc=%0d ch_inc=%b ch_empty=%b required one-hot or zero on non-empty", cyc, ch_inc, ch_empty);
        end
        if (out_valid && out_ready) begin
            rx_q.push_back({out_ch, out_data});
            rx_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (inc_seen[i] && fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
        end
        refresh();
        cyc++;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) fifo_q[i].delete();
        refresh();
        rx_q.delete();
        rx_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) fifo_q[i].delete();
        fifo_q[1].push_back(8'h5A);
        refresh();
        repeat (2) @(posedge clk);
        #1;
        vec_cnt++;
        if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        vec_cnt++;
        if (out_data !== 8'h00) begin err_cnt++; $display("FAIL reset_data got=%h exp=00", out_data); end
        vec_cnt++;
        if (out_ch !== 2'd0) begin err_cnt++; $display("FAIL reset_ch got=%0d exp=0", out_ch); end
        vec_cnt++;
        if (ch_inc !== 4'b0000) begin err_cnt++; $display("FAIL reset_inc got=%b exp=0000", ch_inc); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        fifo_q[2].push_back(8'hA0);
        fifo_q[2].push_back(8'hA1);
        refresh();
        tick();
        vec_cnt++;
        if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL single_lat1 valid got=%b exp=0", out_valid); end
        tick();
        vec_cnt++;
        if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 8'hA0})
            begin err_cnt++; $display("FAIL single_w0 got v=%b ch=%0d d=%h exp v=1 ch=2 d=a0", out_valid, out_ch, out_data); end
        tick();
        vec_cnt++;
        if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 8'hA1})
            begin err_cnt++; $display("FAIL single_w1 got v=%b ch=%0d d=%h exp v=1 ch=2 d=a1", out_valid, out_ch, out_data); end
        tick();
        vec_cnt++;
        if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL single_end valid got=%b exp=0", out_valid); end
        tick();
        vec_cnt++;
        if (rx_q.size() != 2 || rx_q[0] !== {2'd2, 8'hA0} || rx_q[1] !== {2'd2, 8'hA1})
            begin err_cnt++; $display("FAIL single_seq got size=%0d required 2 words a0,a1 on ch2", rx_q.size()); end
        $display("test_single done, %0d words", rx_q.size());
    endtask

    task automatic test_rotation();
        logic [9:0] exp;
        int         c;
        int         k;
        int         gap;
        do_reset();
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int w = 0; w < 8; w++) fifo_q[ch].push_back(8'(ch*16 + w));
        refresh();
        for (int t = 0; t < 200 && rx_q.size() < 32; t++) tick();
        vec_cnt++;
        if (rx_q.size() != 32) begin err_cnt++; $display("FAIL rot_timeout got=%0d words exp=32", rx_q.size()); end
        for (int i = 0; i < 32 && i < rx_q.size(); i++) begin
            c   = (i / 4) % 4;
            k   = (i / 16) * 4 + (i % 4);
            exp = {2'(c), 8'(c*16 + k)};
            vec_cnt++;
            if (rx_q[i] !== exp) begin err_cnt++; $display("FAIL rot_word%0d got=%h exp=%h", i, rx_q[i], exp); end
            if (i > 0) begin
                gap = (i % 4 == 0) ? 2 : 1;
                vec_cnt++;
                if (rx_cyc[i] - rx_cyc[i-1] != gap)
                    begin err_cnt++; $display("FAIL rot_gap%0d got=%0d exp=%0d", i, rx_cyc[i] - rx_cyc[i-1], gap); end
            end
        end
        $display("test_rotation done, %0d words", rx_q.size());
    endtask

    task automatic test_backpressure();
        logic [9:0]    exp [9];
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic [1:0]    prev_ch;
        exp = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h110, 10'h111, 10'h112, 10'h004, 10'h005};
        do_reset();
        for (int w = 0; w < 6; w++) fifo_q[0].push_back(8'(w));
        for (int w = 0; w < 3; w++) fifo_q[1].push_back(8'(8'h10 + w));
        refresh();
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_ch    = '0;
        out_ready  = 1'b0;
        for (int t = 0; t < 300 && rx_q.size() < 9; t++) begin
            tick();
            if (prev_stall) begin
                vec_cnt++;
                if (!s_valid || s_data !== prev_data || s_ch !== prev_ch)
                    begin err_cnt++; $display("FAIL bp_hold cyc=%0d got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h", cyc, s_valid, s_ch, s_data, prev_ch, prev_data); end
            end
            if (s_valid && !s_ready) begin
                vec_cnt++;
                if (inc_seen !== 4'b0000) begin err_cnt++; $display("FAIL bp_inc cyc=%0d got=%b exp=0000", cyc, inc_seen); end
            end
            prev_stall = s_valid && !s_ready;
            prev_data  = s_data;
            prev_ch    = s_ch;
            out_ready  = ~out_ready;
        end
        out_ready = 1'b1;
        repeat (4) tick();
        vec_cnt++;
        if (rx_q.size() != 9) begin err_cnt++; $display("FAIL bp_count got=%0d exp=9", rx_q.size()); end
        for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
            vec_cnt++;
            if (rx_q[i] !== exp[i]) begin err_cnt++; $display("FAIL bp_word%0d got=%h exp=%h", i, rx_q[i], exp[i]); end
        end
        $display("test_backpressure done, %0d words", rx_q.size());
    endtask

    task automatic test_dry();
        logic [9:0] exp [10];
        logic       refilled;
        exp = '{10'h110, 10'h111, 10'h220, 10'h221, 10'h222, 10'h223, 10'h330, 10'h112, 10'h113, 10'h224};
        do_reset();
        fifo_q[1].push_back(8'h10);
        fifo_q[1].push_back(8'h11);
        for (int w = 0; w < 5; w++) fifo_q[2].push_back(8'(8'h20 + w));
        fifo_q[3].push_back(8'h30);
        refresh();
        refilled = 1'b0;
        for (int t = 0; t < 200 && rx_q.size() < 10; t++) begin
            tick();
            if (!refilled && rx_q.size() >= 3) begin
                fifo_q[1].push_back(8'h12);
                fifo_q[1].push_back(8'h13);
                refresh();
                refilled = 1'b1;
            end
        end
        vec_cnt++;
        if (rx_q.size() != 10) begin err_cnt++; $display("FAIL dry_count got=%0d exp=10", rx_q.size()); end
        for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
            vec_cnt++;
            if (rx_q[i] !== exp[i]) begin err_cnt++; $display("FAIL dry_word%0d got=%h exp=%h", i, rx_q[i], exp[i]); end
        end
        $display("test_dry done, %0d words", rx_q.size());
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int w = 0; w < 8; w++) begin
            fifo_q[1].push_back(8'(8'h10 + w));
            fifo_q[2].push_back(8'(8'h20 + w));
        end
        refresh();
        repeat (3) tick();
        vec_cnt++;
        if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL ar_pre valid got=%b exp=1", out_valid); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({out_valid, out_data, out_ch} !== 11'd0)
            begin err_cnt++; $display("FAIL ar_clear got v=%b d=%h ch=%0d exp 0", out_valid, out_data, out_ch); end
        vec_cnt++;
        if (ch_inc !== 4'b0000) begin err_cnt++; $display("FAIL ar_inc got=%b exp=0000", ch_inc); end
        fifo_q[0].push_back(8'h05);
        fifo_q[0].push_back(8'h06);
        refresh();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rx_q.delete();
        rx_cyc.delete();
        for (int t = 0; t < 20 && rx_q.size() == 0; t++) tick();
        vec_cnt++;
        if (rx_q.size() == 0 || rx_q[0] !== {2'd0, 8'h05})
            begin err_cnt++; $display("FAIL ar_first got=%h exp=005 size=%0d", (rx_q.size() > 0) ? rx_q[0] : 10'h3FF, rx_q.size()); end
        $display("test_async_reset done");
    endtask

`ifdef FIFO_RR_SCHED_STATS_EN
    task automatic test_stats();
        int pops;
        do_reset();
        pops = 0;
        for (int t = 0; t < 95000 && pops < 70000; t++) begin
            while (fifo_q[3].size() < 2) fifo_q[3].push_back(8'h3F);
            refresh();
            tick();
            if (inc_seen[3]) pops++;
        end
        vec_cnt++;
        if (pops != 70000) begin err_cnt++; $display("FAIL stats_pops got=%0d exp=70000", pops); end
        vec_cnt++;
        if (pop_cnt[3*16 +: 16] !== 16'd4464) begin err_cnt++; $display("FAIL stats_ch3 got=%0d exp=4464", pop_cnt[3*16 +: 16]); end
        vec_cnt++;
        if (pop_cnt[47:0] !== 48'd0) begin err_cnt++; $display("FAIL stats_others got=%h exp=0", pop_cnt[47:0]); end
        $display("test_stats done, %0d pops", pops);
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        ch_empty  = '1;
        ch_data   = '0;
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_dry();
        test_async_reset();
`ifdef FIFO_RR_SCHED_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
